dac_frame_scheduler: RTL and testbench

Sequences the 16-bit serial DAC transmitter across all DAC channels. It holds one code register per channel and snapshots them on a frame trigger. It then issues one serial word per enabled channel through the transmitter start/done handshake. A broadcast LDAC word closes each frame so all outputs update together. It sits between the AXI register file / PWM-synchronous trigger and the serial transmitter in the DAC IP.

---
 rtl/dac_pkg.sv | 31 +++
 rtl/dac_code_bank.sv | 55 +++++
 rtl/dac_frame_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_dac_frame_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC frame scheduler: FSM encoding, serial word
// layout and the helper that packs a channel word.
package dac_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_SCAN       = 4'd1,
        S_START      = 4'd2,
        S_WAIT_LO    = 4'd3,
        S_WAIT_HI    = 4'd4,
        S_LDAC_START = 4'd5,
        S_LDAC_LO    = 4'd6,
        S_LDAC_HI    = 4'd7,
        S_FINISH     = 4'd8
    } state_e;

    localparam logic [15:0] LDAC_WORD = 16'h8000;
    localparam int          CMD_BIT   = 15;
    localparam int          ADDR_MSB  = 14;
    localparam int          ADDR_LSB  = 12;

    function automatic logic [15:0] ch_word(input logic [2:0] ch, input logic [11:0] code);
        logic [15:0] word;
        word                     = 16'h0000;
        word[CMD_BIT]            = 1'b0;
        word[ADDR_MSB:ADDR_LSB]  = ch;
        word[ADDR_LSB-1:0]       = code;
        return word;
    endfunction

endpackage

// File: rtl/dac_code_bank.sv
// Per-channel DAC code registers with a shadow copy taken at frame snapshot,
// so a frame in flight always reads a coherent set of codes.
module dac_code_bank #(
    parameter int NUM_CH = 8,
    parameter int CODE_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [CODE_W-1:0] wr_code,
    input  logic              snap,
    input  logic [2:0]        rd_idx,
    output logic [CODE_W-1:0] rd_code
);

    logic [CODE_W-1:0] r_code   [NUM_CH];
    logic [CODE_W-1:0] r_shadow [NUM_CH];

    // Live write port and snapshot copy; a same-cycle write lands after the copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_code[i]   <= {CODE_W{1'b0}};
                r_shadow[i] <= {CODE_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en && (wr_ch == 3'(i))) begin
                    r_code[i] <= wr_code;
                end else begin
                    r_code[i] <= r_code[i];
                end
                if (snap) begin
                    r_shadow[i] <= r_code[i];
                end else begin
                    r_shadow[i] <= r_shadow[i];
                end
            end
        end
    end

    // Shadow read mux; out-of-range indices read as zero.
    always_comb begin
        rd_code = {CODE_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_idx == 3'(i)) begin
                rd_code = r_shadow[i];
            end else begin
                rd_code = rd_code;
            end
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Frame sequencer: snapshots channel codes on trigger, sends one serial word
// per enabled channel over the start/done handshake, then a broadcast LDAC.
module dac_frame_scheduler
    import dac_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CODE_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [CODE_W-1:0] wr_code,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              trigger,
    input  logic              overrun_clr,
    output logic [15:0]       tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CH);

    state_e            r_state;
    state_e            w_next_state;
    logic [3:0]        r_ch_idx;
    logic [3:0]        w_next_idx;
    logic              w_snap;
    logic [NUM_CH-1:0] r_mask_shadow;
    logic [7:0]        w_mask8;
    logic              w_any_mask;
    logic              w_ch_en;
    logic [CODE_W-1:0] w_rd_code;
    logic              r_pending;
    logic              r_overrun;
    logic              r_tx_start;
    logic [15:0]       r_tx_data;
    logic              r_busy;
    logic              r_frame_done;

    assign w_mask8    = 8'(r_mask_shadow);
    assign w_any_mask = |r_mask_shadow;
    assign w_ch_en    = w_mask8[r_ch_idx[2:0]];

    dac_code_bank #(
        .NUM_CH (NUM_CH),
        .CODE_W (CODE_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_code (wr_code),
        .snap    (w_snap),
        .rd_idx  (r_ch_idx[2:0]),
        .rd_code (w_rd_code)
    );

    // State, channel index and mask shadow registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ch_idx      <= 4'd0;
            r_mask_shadow <= {NUM_CH{1'b0}};
        end else begin
            r_state  <= w_next_state;
            r_ch_idx <= w_next_idx;
            if (w_snap) begin
                r_mask_shadow <= ch_mask;
            end else begin
                r_mask_shadow <= r_mask_shadow;
            end
        end
    end

    // Next-state logic. An empty mask skips the scan so an idle frame still
    // completes in three cycles.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_ch_idx;
        w_snap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (trigger || r_pending) begin
                    w_snap       = 1'b1;
                    w_next_idx   = 4'd0;
                    w_next_state = S_SCAN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SCAN: begin
                if (!w_any_mask) begin
                    w_next_state = S_FINISH;
                end else if (r_ch_idx == LAST_IDX) begin
                    w_next_state = S_LDAC_START;
                end else if (w_ch_en) begin
                    w_next_state = S_START;
                end else begin
                    w_next_idx   = r_ch_idx + 4'd1;
                    w_next_state = S_SCAN;
                end
            end
            S_START:      w_next_state = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!tx_done) begin
                    w_next_state = S_WAIT_HI;
                end else begin
                    w_next_state = S_WAIT_LO;
                end
            end
            S_WAIT_HI: begin
                if (tx_done) begin
                    w_next_idx   = r_ch_idx + 4'd1;
                    w_next_state = S_SCAN;
                end else begin
                    w_next_state = S_WAIT_HI;
                end
            end
            S_LDAC_START: w_next_state = S_LDAC_LO;
            S_LDAC_LO: begin
                if (!tx_done) begin
                    w_next_state = S_LDAC_HI;
                end else begin
                    w_next_state = S_LDAC_LO;
                end
            end
            S_LDAC_HI: begin
                if (tx_done) begin
                    w_next_state = S_FINISH;
                end else begin
                    w_next_state = S_LDAC_HI;
                end
            end
            S_FINISH:     w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    // Registered outputs plus pending/overrun bookkeeping; overrun set beats clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_start   <= 1'b0;
            r_tx_data    <= 16'h0000;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_pending    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_tx_start   <= (r_state == S_START) || (r_state == S_LDAC_START);
            r_frame_done <= (r_state == S_FINISH);
            if (r_state == S_START) begin
                r_tx_data <= ch_word(r_ch_idx[2:0], 12'(w_rd_code));
            end else if (r_state == S_LDAC_START) begin
                r_tx_data <= LDAC_WORD;
            end else begin
                r_tx_data <= r_tx_data;
            end
            if (w_snap) begin
                r_busy <= 1'b1;
            end else if (r_state == S_FINISH) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
            if (w_snap) begin
                r_pending <= 1'b0;
            end else if (trigger && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end else begin
                r_pending <= r_pending;
            end
            if (trigger && (r_state != S_IDLE) && r_pending) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler with a simple transmitter model
// that records every word it is asked to send.
module tb_dac_frame_scheduler;
    import dac_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [11:0] wr_code;
    logic [7:0]  ch_mask;
    logic        trigger;
    logic        overrun_clr;
    logic [15:0] tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] words[$];
    int          n_start = 0;
    int          n_fd = 0;
    int          tx_cnt = 0;

    always #5 clk = ~clk;

    dac_frame_scheduler #(.NUM_CH(8), .CODE_W(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_code     (wr_code),
        .ch_mask     (ch_mask),
        .trigger     (trigger),
        .overrun_clr (overrun_clr),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    // Transmitter model: start clears done, done returns four cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_done = 1'b0;
            tx_cnt  = 0;
        end else if (tx_start) begin
            tx_done = 1'b0;
            tx_cnt  = 4;
            words.push_back(tx_data);
            n_start++;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done = 1'b1;
        end
        if (frame_done) n_fd++;
    end

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] ch, input logic [11:0] code);
        wr_en = 1'b1; wr_ch = ch; wr_code = code;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_trig();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int maxc);
        int k;
        k = 0;
        while (frame_done !== 1'b1 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check16(tag, 16'(frame_done), 16'h0001);
    endtask

    task automatic clear_log();
        words.delete();
        n_start = 0;
        n_fd    = 0;
    endtask

    initial begin
        int k;
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = 3'd0; wr_code = 12'h000;
        ch_mask = 8'h00; trigger = 1'b0; overrun_clr = 1'b0;
        tick(3);
        check16("rst_outs", {tx_data[14:0] | 15'(tx_start), 1'b0}, 16'h0000);
        check16("rst_flags", {13'h0000, busy, frame_done, overrun}, 16'h0000);
        rst_n = 1'b1;
        tick(1);

        // All channels enabled, codes 0x100*ch.
        for (int i = 0; i < 8; i++) wr(3'(i), 12'(i * 256));
        ch_mask = 8'hFF;
        clear_log();
        pulse_trig();
        check16("t1_busy", 16'(busy), 16'h0001);
        check16("t1_start_n1", 16'(tx_start), 16'h0000);
        tick(1);
        check16("t1_start_n2", 16'(tx_start), 16'h0000);
        tick(1);
        check16("t1_latency", 16'(tx_start), 16'h0001);
        check16("t1_first", tx_data, 16'h0000);
        wait_fd("t1_fd", 300);
        tick(1);
        check16("t1_fd_pulse", 16'(frame_done), 16'h0000);
        check16("t1_nfd", 16'(n_fd), 16'h0001);
        check16("t1_idle", 16'(busy), 16'h0000);
        check16("t1_nstart", 16'(n_start), 16'h0009);
        for (int i = 0; i < 8; i++) check16($sformatf("t1_w%0d", i), words[i], 16'(i * 'h1100));
        check16("t1_ldac", words[8], 16'h8000);

        // Sparse mask.
        wr(3'd0, 12'hABC);
        wr(3'd2, 12'h123);
        ch_mask = 8'b0000_0101;
        clear_log();
        pulse_trig();
        wait_fd("t2_fd", 300);
        tick(1);
        check16("t2_nstart", 16'(n_start), 16'h0003);
        check16("t2_w0", words[0], 16'h0ABC);
        check16("t2_w1", words[1], 16'h2123);
        check16("t2_w2", words[2], 16'h8000);

        // Empty mask: no traffic, frame_done three cycles after trigger.
        ch_mask = 8'h00;
        clear_log();
        pulse_trig();
        check16("t3_fd_n1", 16'(frame_done), 16'h0000);
        tick(1);
        check16("t3_fd_n2", 16'(frame_done), 16'h0000);
        tick(1);
        check16("t3_fd_n3", 16'(frame_done), 16'h0001);
        tick(2);
        check16("t3_nstart", 16'(n_start), 16'h0000);
        check16("t3_nfd", 16'(n_fd), 16'h0001);

        // Writes during and coincident with a snapshot.
        ch_mask = 8'h01;
        clear_log();
        pulse_trig();
        wr(3'd0, 12'hFFF);
        wait_fd("t4_fd_a", 300);
        tick(1);
        check16("t4_old", words[0], 16'h0ABC);
        check16("t4_old_ldac", words[1], 16'h8000);
        clear_log();
        trigger = 1'b1; wr_en = 1'b1; wr_ch = 3'd0; wr_code = 12'h555;
        @(negedge clk);
        trigger = 1'b0; wr_en = 1'b0;
        wait_fd("t4_fd_b", 300);
        tick(1);
        check16("t4_new", words[0], 16'h0FFF);
        clear_log();
        pulse_trig();
        wait_fd("t4_fd_c", 300);
        tick(1);
        check16("t4_same_cycle", words[0], 16'h0555);

        // Repeated triggers: one extra frame, sticky overrun, set beats clear.
        clear_log();
        check16("t5_ovr0", 16'(overrun), 16'h0000);
        pulse_trig();
        tick(1);
        pulse_trig();
        pulse_trig();
        check16("t5_ovr", 16'(overrun), 16'h0001);
        trigger = 1'b1; overrun_clr = 1'b1;
        @(negedge clk);
        trigger = 1'b0; overrun_clr = 1'b0;
        check16("t5_set_wins", 16'(overrun), 16'h0001);
        wait_fd("t5_fd_a", 300);
        tick(1);
        wait_fd("t5_fd_b", 300);
        tick(40);
        check16("t5_nfd", 16'(n_fd), 16'h0002);
        check16("t5_nstart", 16'(n_start), 16'h0004);
        check16("t5_w2", words[2], 16'h0555);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check16("t5_clr", 16'(overrun), 16'h0000);

        // Reset while waiting for the transmitter.
        ch_mask = 8'hFF;
        clear_log();
        pulse_trig();
        tick(1);
        pulse_trig();
        pulse_trig();
        k = 0;
        while (tx_start !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check16("t6_seen_start", 16'(tx_start), 16'h0001);
        tick(1);
        check16("t6_in_wait_hi", 16'(dut.r_state), 16'(S_WAIT_HI));
        check16("t6_ovr_pre", 16'(overrun), 16'h0001);
        rst_n = 1'b0;
        @(negedge clk);
        check16("t6_state", 16'(dut.r_state), 16'(S_IDLE));
        check16("t6_flags", {13'h0000, busy, tx_start, overrun}, 16'h0000);
        rst_n = 1'b1;
        tick(1);
        clear_log();
        pulse_trig();
        wait_fd("t6_fd", 300);
        tick(1);
        check16("t6_nstart", 16'(n_start), 16'h0009);
        check16("t6_w0", words[0], 16'h0000);
        check16("t6_w1", words[1], 16'h1000);
        check16("t6_ldac", words[8], 16'h8000);
        tick(50);
        check16("t6_no_extra", 16'(n_fd), 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
